// File: rtl/ap_ctrl_perf_monitor.sv
// ap_ctrl_perf_monitor
//   Per-channel activity/latency monitor for ap_ctrl_hs style sub-modules.
//   Each channel tracks one transaction at a time.
//   A transaction starts on ap_start and ends on the done handshake
//   (ap_done & ap_continue).
//   For every channel the monitor keeps these statistics:
//     - transaction count
//     - last, minimum and maximum latency
//     - busy cycles
//     - stall cycles (ap_done held while ap_continue is low)
//     - accepted starts (ap_start & ap_ready)
//     - a sticky protocol-error flag
//   All counters saturate at all-ones.
//
// Ports
//   ap_clk, ap_rst_n         clock, asynchronous active-low reset
//   ap_start/ap_ready        per-channel start handshake
//   ap_done/ap_continue      per-channel done handshake
//   finish                   freezes every FSM and statistic while high
//   clear                    synchronous clear of statistics, errors and FSMs
//   rd_en/rd_ch/rd_sel       read request (channel, statistic select)
//   rd_valid/rd_data         registered read response, one cycle after rd_en
//   busy                     per-channel "FSM not idle", registered
//
// rd_sel: 0 txn, 1 last_lat, 2 min_lat, 3 max_lat, 4 busy_cnt, 5 stall_cnt,
//         6 acc_cnt, 7 {err, state[1:0]}

module ap_ctrl_perf_monitor #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int CH_W   = 5
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic [NUM_CH-1:0] ap_start,
  input  logic [NUM_CH-1:0] ap_ready,
  input  logic [NUM_CH-1:0] ap_done,
  input  logic [NUM_CH-1:0] ap_continue,
  input  logic              finish,
  input  logic              clear,
  input  logic              rd_en,
  input  logic [CH_W-1:0]   rd_ch,
  input  logic [2:0]        rd_sel,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  rd_data,
  output logic [NUM_CH-1:0] busy
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BUSY      = 2'd1,
    DONE_WAIT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  state_t           state_q     [NUM_CH];
  state_t           state_d     [NUM_CH];
  logic [CNT_W-1:0] lat_q       [NUM_CH];
  logic [CNT_W-1:0] lat_d       [NUM_CH];
  logic [CNT_W-1:0] txn_q       [NUM_CH];
  logic [CNT_W-1:0] txn_d       [NUM_CH];
  logic [CNT_W-1:0] last_lat_q  [NUM_CH];
  logic [CNT_W-1:0] last_lat_d  [NUM_CH];
  logic [CNT_W-1:0] min_lat_q   [NUM_CH];
  logic [CNT_W-1:0] min_lat_d   [NUM_CH];
  logic [CNT_W-1:0] max_lat_q   [NUM_CH];
  logic [CNT_W-1:0] max_lat_d   [NUM_CH];
  logic [CNT_W-1:0] busy_cnt_q  [NUM_CH];
  logic [CNT_W-1:0] busy_cnt_d  [NUM_CH];
  logic [CNT_W-1:0] stall_cnt_q [NUM_CH];
  logic [CNT_W-1:0] stall_cnt_d [NUM_CH];
  logic [CNT_W-1:0] acc_cnt_q   [NUM_CH];
  logic [CNT_W-1:0] acc_cnt_d   [NUM_CH];
  logic             err_q       [NUM_CH];
  logic             err_d       [NUM_CH];

  logic [CNT_W-1:0] rd_value;

  // Next-state and statistic update for every channel.
  // clear overrides finish; finish holds everything.
  always_comb begin
    logic             acc_c;
    logic             dhs_c;
    logic             stall_c;
    logic             cmpl_c;
    logic [CNT_W-1:0] cmpl_lat;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      state_d[i]     = state_q[i];
      lat_d[i]       = lat_q[i];
      txn_d[i]       = txn_q[i];
      last_lat_d[i]  = last_lat_q[i];
      min_lat_d[i]   = min_lat_q[i];
      max_lat_d[i]   = max_lat_q[i];
      busy_cnt_d[i]  = busy_cnt_q[i];
      stall_cnt_d[i] = stall_cnt_q[i];
      acc_cnt_d[i]   = acc_cnt_q[i];
      err_d[i]       = err_q[i];
      acc_c          = ap_start[i] & ap_ready[i];
      dhs_c          = ap_done[i] & ap_continue[i];
      stall_c        = ap_done[i] & ~ap_continue[i];
      cmpl_c         = 1'b0;
      cmpl_lat       = '0;

      if (clear) begin
        state_d[i]     = IDLE;
        lat_d[i]       = '0;
        txn_d[i]       = '0;
        last_lat_d[i]  = '0;
        min_lat_d[i]   = '1;
        max_lat_d[i]   = '0;
        busy_cnt_d[i]  = '0;
        stall_cnt_d[i] = '0;
        acc_cnt_d[i]   = '0;
        err_d[i]       = 1'b0;
      end else if (!finish) begin
        if (acc_c) begin
          acc_cnt_d[i] = sat_inc(acc_cnt_q[i]);
        end
        // The start cycle already counts as busy even though the FSM is IDLE.
        if ((state_q[i] != IDLE) || ap_start[i]) begin
          busy_cnt_d[i] = sat_inc(busy_cnt_q[i]);
        end

        unique case (state_q[i])
          IDLE: begin
            if (ap_start[i]) begin
              if (dhs_c) begin
                cmpl_c   = 1'b1;
                cmpl_lat = CNT_ONE;
              end else begin
                state_d[i] = BUSY;
                lat_d[i]   = CNT_ONE;
              end
            end else if (dhs_c) begin
              err_d[i] = 1'b1;
            end
          end
          BUSY, DONE_WAIT: begin
            if (dhs_c) begin
              cmpl_c   = 1'b1;
              cmpl_lat = sat_inc(lat_q[i]);
              // Back-to-back: the completing cycle is also cycle 1 of the next one.
              if (ap_start[i]) begin
                state_d[i] = BUSY;
                lat_d[i]   = CNT_ONE;
              end else begin
                state_d[i] = IDLE;
                lat_d[i]   = '0;
              end
            end else begin
              lat_d[i] = sat_inc(lat_q[i]);
              if (stall_c) begin
                state_d[i]     = DONE_WAIT;
                stall_cnt_d[i] = sat_inc(stall_cnt_q[i]);
              end
            end
          end
          default: state_d[i] = IDLE;
        endcase

        if (cmpl_c) begin
          txn_d[i]      = sat_inc(txn_q[i]);
          last_lat_d[i] = cmpl_lat;
          if (cmpl_lat < min_lat_q[i]) begin
            min_lat_d[i] = cmpl_lat;
          end
          if (cmpl_lat > max_lat_q[i]) begin
            max_lat_d[i] = cmpl_lat;
          end
        end
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state_q[i]     <= IDLE;
        lat_q[i]       <= '0;
        txn_q[i]       <= '0;
        last_lat_q[i]  <= '0;
        min_lat_q[i]   <= '1;
        max_lat_q[i]   <= '0;
        busy_cnt_q[i]  <= '0;
        stall_cnt_q[i] <= '0;
        acc_cnt_q[i]   <= '0;
        err_q[i]       <= 1'b0;
        busy[i]        <= 1'b0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state_q[i]     <= state_d[i];
        lat_q[i]       <= lat_d[i];
        txn_q[i]       <= txn_d[i];
        last_lat_q[i]  <= last_lat_d[i];
        min_lat_q[i]   <= min_lat_d[i];
        max_lat_q[i]   <= max_lat_d[i];
        busy_cnt_q[i]  <= busy_cnt_d[i];
        stall_cnt_q[i] <= stall_cnt_d[i];
        acc_cnt_q[i]   <= acc_cnt_d[i];
        err_q[i]       <= err_d[i];
        busy[i]        <= (state_d[i] != IDLE);
      end
    end
  end

  // Read mux works from the current registers, so a read coinciding with
  // an update returns the pre-update value. Channels >= NUM_CH read as 0.
  always_comb begin
    rd_value = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (rd_ch == CH_W'(i)) begin
        case (rd_sel)
          3'd0:    rd_value = txn_q[i];
          3'd1:    rd_value = last_lat_q[i];
          3'd2:    rd_value = min_lat_q[i];
          3'd3:    rd_value = max_lat_q[i];
          3'd4:    rd_value = busy_cnt_q[i];
          3'd5:    rd_value = stall_cnt_q[i];
          3'd6:    rd_value = acc_cnt_q[i];
          default: rd_value = {{(CNT_W-3){1'b0}}, err_q[i], state_q[i]};
        endcase
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= rd_value;
      end
    end
  end

endmodule

// File: tb/tb_ap_ctrl_perf_monitor.sv
`timescale 1ns/1ps
module tb_ap_ctrl_perf_monitor;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam int CH_W   = 3;
  localparam longint SAT = 255;

  logic              ap_clk = 1'b0;
  logic              ap_rst_n;
  logic [NUM_CH-1:0] ap_start, ap_ready, ap_done, ap_continue;
  logic              finish, clear, rd_en;
  logic [CH_W-1:0]   rd_ch;
  logic [2:0]        rd_sel;
  logic              rd_valid;
  logic [CNT_W-1:0]  rd_data;
  logic [NUM_CH-1:0] busy;

  ap_ctrl_perf_monitor #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .CH_W(CH_W)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
    .finish(finish), .clear(clear),
    .rd_en(rd_en), .rd_ch(rd_ch), .rd_sel(rd_sel),
    .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy)
  );

  always #5 ap_clk = ~ap_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (time/event based) ----------------
  typedef struct packed {
    logic [2:0] ch;
    logic [2:0] sel;
    logic [7:0] data;
  } exp_t;
  exp_t exp_q[$];

  longint now_m;                     // active (unfrozen, uncleared) cycle number
  bit     inflight_m [NUM_CH];
  bit     parked_m   [NUM_CH];       // done seen but held back by ap_continue
  bit     err_m      [NUM_CH];
  longint start_m    [NUM_CH];
  longint txn_m      [NUM_CH];
  longint busy_m     [NUM_CH];
  longint stall_m    [NUM_CH];
  longint acc_m      [NUM_CH];
  longint last_m     [NUM_CH];
  longint min_m      [NUM_CH];
  longint max_m      [NUM_CH];

  function automatic logic [7:0] sat8(input longint x);
    return (x > SAT) ? 8'hFF : 8'(x);
  endfunction

  function automatic void model_clear();
    for (int c = 0; c < NUM_CH; c++) begin
      inflight_m[c] = 0; parked_m[c] = 0; err_m[c] = 0; start_m[c] = 0;
      txn_m[c] = 0; busy_m[c] = 0; stall_m[c] = 0; acc_m[c] = 0;
      last_m[c] = 0; min_m[c] = SAT; max_m[c] = 0;
    end
  endfunction

  function automatic void record(input int c, input longint lat);
    longint l;
    l = (lat > SAT) ? SAT : lat;
    txn_m[c]++;
    last_m[c] = l;
    if (l < min_m[c]) min_m[c] = l;
    if (l > max_m[c]) max_m[c] = l;
  endfunction

  function automatic void model_step();
    now_m++;
    for (int c = 0; c < NUM_CH; c++) begin
      bit st, dh, sl;
      st = ap_start[c];
      dh = ap_done[c] & ap_continue[c];
      sl = ap_done[c] & ~ap_continue[c];
      if (ap_start[c] && ap_ready[c]) acc_m[c]++;
      if (inflight_m[c] || st) busy_m[c]++;
      if (!inflight_m[c]) begin
        if (st && dh) record(c, 1);
        else if (st) begin inflight_m[c] = 1; parked_m[c] = 0; start_m[c] = now_m; end
        else if (dh) err_m[c] = 1;
      end else if (dh) begin
        record(c, now_m - start_m[c] + 1);
        if (st) begin start_m[c] = now_m; parked_m[c] = 0; end
        else inflight_m[c] = 0;
      end else if (sl) begin
        stall_m[c]++;
        parked_m[c] = 1;
      end
    end
  endfunction

  function automatic logic [7:0] model_read(input int ch, input int sel);
    logic [1:0] st;
    if (ch >= NUM_CH) return 8'h00;
    st = !inflight_m[ch] ? 2'd0 : (parked_m[ch] ? 2'd2 : 2'd1);
    case (sel)
      0: return sat8(txn_m[ch]);
      1: return sat8(last_m[ch]);
      2: return sat8(min_m[ch]);
      3: return sat8(max_m[ch]);
      4: return sat8(busy_m[ch]);
      5: return sat8(stall_m[ch]);
      6: return sat8(acc_m[ch]);
      default: return {5'b0, err_m[ch], st};
    endcase
  endfunction

  function automatic logic [NUM_CH-1:0] model_busy();
    logic [NUM_CH-1:0] b;
    for (int c = 0; c < NUM_CH; c++) b[c] = inflight_m[c];
    return b;
  endfunction

  // Model advances on the same edge as the DUT; expected read data is the
  // pre-update view.
  always @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      model_clear();
      now_m = 0;
      exp_q.delete();
    end else begin
      if (rd_en) exp_q.push_back('{ch: rd_ch, sel: rd_sel, data: model_read(int'(rd_ch), int'(rd_sel))});
      if (clear) model_clear();
      else if (!finish) model_step();
    end
  end

  // ---------------- monitor ----------------
  exp_t e;
  always @(negedge ap_clk) begin
    if (ap_rst_n) begin
      check("busy", busy, model_busy());
      check("rd_valid", rd_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (rd_valid) check($sformatf("rd_data ch%0d sel%0d", e.ch, e.sel), rd_data, e.data);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge ap_clk);
    #1;
  endtask

  task automatic idle();
    ap_start = '0; ap_ready = '0; ap_done = '0; ap_continue = '1; rd_en = 1'b0;
  endtask

  task automatic rand_read();
    rd_en  = ($urandom % 2) == 1;
    rd_ch  = CH_W'($urandom_range(0, 7));
    rd_sel = 3'($urandom_range(0, 7));
  endtask

  task automatic read(input int ch, input int sel);
    rd_en = 1'b1; rd_ch = CH_W'(ch); rd_sel = 3'(sel);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic read_all(input int ch);
    for (int s = 0; s < 8; s++) read(ch, s);
    tick();
  endtask

  // Start at t=0, ap_done from t=d, ap_continue low for s cycles after that.
  task automatic drive_txn(input int ch, input int d, input int s);
    for (int t = 0; t <= d + s; t++) begin
      idle();
      ap_start[ch]    = (t == 0);
      ap_ready[ch]    = (t == 0);
      ap_done[ch]     = (t >= d);
      ap_continue[ch] = (t >= d + s);
      rand_read();
      tick();
    end
    idle();
    tick();
  endtask

  task automatic rand_hs();
    for (int c = 0; c < NUM_CH; c++) begin
      ap_start[c]    = ($urandom % 4) == 0;
      ap_ready[c]    = ($urandom % 2) == 0;
      ap_done[c]     = ($urandom % 4) == 0;
      ap_continue[c] = ($urandom % 4) != 0;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    ap_rst_n = 1'b0; idle(); finish = 1'b0; clear = 1'b0; rd_ch = '0; rd_sel = '0;
    repeat (3) tick();
    check("reset rd_valid", rd_valid, 0);
    check("reset rd_data", rd_data, 0);
    check("reset busy", busy, 0);
    ap_rst_n = 1'b1;
    tick();
    read(0, 2);
    read(0, 0);
    tick();

    // ch1: latencies 6, 4, 9
    drive_txn(1, 5, 0);
    drive_txn(1, 3, 0);
    drive_txn(1, 8, 0);
    read_all(1);

    // ch2: done at 5, continue low 3 cycles -> latency 9, stall 3; then a 1-cycle txn
    drive_txn(2, 5, 3);
    read_all(2);
    drive_txn(2, 0, 0);
    read_all(2);

    // ch0: back-to-back, start held, done every 3rd cycle -> latency 4 each
    for (int t = 0; t <= 15; t++) begin
      idle();
      ap_start[0] = (t < 15);
      ap_ready[0] = (t < 15);
      ap_done[0]  = (t > 0) && (t % 3 == 0);
      rand_read();
      tick();
    end
    idle();
    read_all(0);

    // ch3: 300-cycle transaction saturates the 8-bit latency
    drive_txn(3, 299, 0);
    read_all(3);

    // clear mid-transaction, then an orphan done raises err
    idle(); ap_start[3] = 1'b1; ap_ready[3] = 1'b1; tick();
    idle(); repeat (4) tick();
    clear = 1'b1; read(3, 7); clear = 1'b0;
    repeat (2) tick();
    ap_done[3] = 1'b1; tick();
    idle();
    read_all(3);

    // finish freezes everything while reads keep working
    idle(); ap_start[1] = 1'b1; ap_ready[1] = 1'b1; tick();
    idle(); repeat (3) tick();
    finish = 1'b1;
    repeat (20) begin rand_hs(); rand_read(); tick(); end
    idle();
    read_all(1);
    read(4, 0);
    read(7, 6);
    finish = 1'b0;
    tick();
    ap_done[1] = 1'b1; tick();
    idle();
    read_all(1);

    // randomized traffic with occasional clear and finish windows
    repeat (3000) begin
      rand_hs();
      rand_read();
      clear = ($urandom % 300) == 0;
      if (($urandom % 64) == 0) finish = ~finish;
      tick();
    end
    idle(); finish = 1'b0; clear = 1'b0;
    tick();
    for (int c = 0; c <= NUM_CH; c++) read_all(c);
    repeat (3) tick();
    check("scoreboard drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
